// File: rtl/ext_io_trace_buffer.sv
// Wishbone-mapped GPIO change tracer: records {timestamp, probe} whenever the
// probe bus changes, buffers entries in a circular FIFO drained over the bus.
module ext_io_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic        ext_clk,
  input  logic        ext_rst_n,
  input  logic        wb_sel_io,
  input  logic [29:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_stall,
  input  logic [31:0] probe,
  output logic        irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TS_W + 32;

  logic             enable_q, enable_d;
  logic             irq_en_q, irq_en_d;
  logic [6:0]       thr_q, thr_d;
  logic             en_prev_q;
  logic [31:0]      prev_q;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ack_q;
  logic [31:0]      dat_q, dat_d;
  logic             irq_q, irq_d;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] head;

  logic acc, wr_acc, rd_acc, ctrl_wr, clr, ovf_w1c;
  logic push_req, pop, push_ok, ovf_set, empty, full;
  logic [31:0] rdata;
  logic unused_bits;

  assign unused_bits = ^{wb_adr[29:2], wb_sel[3:1], wb_dat_i[31:15], wb_dat_i[7:3]};

  assign acc     = wb_cyc & wb_stb & wb_sel_io;
  assign wr_acc  = acc & wb_we & wb_sel[0];
  assign rd_acc  = acc & ~wb_we;
  assign ctrl_wr = wr_acc & (wb_adr[1:0] == 2'd0);
  assign clr     = ctrl_wr & wb_dat_i[1];
  assign ovf_w1c = wr_acc & (wb_adr[1:0] == 2'd1) & wb_dat_i[10];

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr_q];

  // The first enabled cycle always records the current probe value as a baseline.
  assign push_req = enable_q & ((probe != prev_q) | ~en_prev_q);
  assign pop      = rd_acc & (wb_adr[1:0] == 2'd3) & ~empty;
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  always_comb begin
    rdata = 32'h0;
    case (wb_adr[1:0])
      2'd0: rdata = {17'h0, thr_q, 5'h0, irq_en_q, 1'b0, enable_q};
      2'd1: rdata = {21'h0, ovf_q, full, empty, 1'b0, 7'(count_q)};
      2'd2: rdata = empty ? 32'h0 : 32'(head[ENT_W-1:32]);
      default: rdata = empty ? 32'h0 : head[31:0];
    endcase
  end

  always_comb begin
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    dat_d    = rd_acc ? rdata : 32'h0;
    irq_d    = irq_en_q & (ovf_q | ((thr_q != 7'd0) & (7'(count_q) >= thr_q)));

    if (ctrl_wr) begin
      enable_d = wb_dat_i[0];
      irq_en_d = wb_dat_i[2];
      thr_d    = wb_dat_i[14:8];
    end
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new overflow in the same cycle as the W1C wins so no drop goes unreported.
    if (ovf_w1c) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    if (clr) begin
      ts_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      thr_q     <= '0;
      en_prev_q <= 1'b0;
      prev_q    <= '0;
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
      thr_q     <= thr_d;
      en_prev_q <= enable_q;
      if (enable_q) prev_q <= probe;
      ts_q      <= ts_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ack_q     <= acc;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge ext_clk) begin
    if (push_ok && !clr) mem[wr_ptr_q] <= {ts_q, probe};
  end

  assign wb_ack   = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_stall = 1'b0;
  assign irq      = irq_q;

endmodule

// File: tb/tb_ext_io_trace_buffer.sv
// Bench for ext_io_trace_buffer: directed scenarios plus randomized bus/probe
// traffic, all compared against a queue-based reference model.
module tb_ext_io_trace_buffer;

  localparam int DEPTH = 16;
  localparam int TS_W  = 16;
  localparam int unsigned TS_MASK = (1 << TS_W) - 1;

  logic        ext_clk = 1'b0;
  logic        ext_rst_n;
  logic        wb_sel_io;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_dat_o;
  logic        wb_ack, wb_stall;
  logic [31:0] probe;
  logic        irq;

  ext_io_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .ext_clk(ext_clk), .ext_rst_n(ext_rst_n), .wb_sel_io(wb_sel_io),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .wb_stall(wb_stall),
    .probe(probe), .irq(irq)
  );

  always #5 ext_clk = ~ext_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_en, m_irq_en, m_was_en, m_ovf;
  bit [6:0]    m_thr;
  bit [31:0]   m_prev;
  int unsigned m_ts;
  bit [31:0]   q_ts[$];
  bit [31:0]   q_val[$];
  bit          exp_ack, exp_irq;
  bit [31:0]   exp_dat;
  bit [31:0]   cur_probe;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_irq_en = 0; m_was_en = 0; m_ovf = 0; m_thr = 0;
    m_prev = 0; m_ts = 0;
    q_ts.delete(); q_val.delete();
    exp_ack = 0; exp_irq = 0; exp_dat = 0;
  endtask

  // One clock edge of the reference model, from the rules of the register map.
  task automatic model_step(input bit acc, input bit we, input bit [3:0] sel,
                            input bit [1:0] a, input bit [31:0] d, input bit [31:0] prb);
    bit wr, rd, push_req, do_pop, clr, irq_next;
    bit [31:0] rdata;
    int n;
    wr = acc && we && sel[0];
    rd = acc && !we;
    n  = q_val.size();
    rdata = 0;
    case (a)
      2'd0: begin rdata[0] = m_en; rdata[2] = m_irq_en; rdata[14:8] = m_thr; end
      2'd1: rdata = n | ((n == 0) << 8) | ((n == DEPTH) << 9) | (m_ovf << 10);
      2'd2: rdata = (n > 0) ? q_ts[0] : 0;
      default: rdata = (n > 0) ? q_val[0] : 0;
    endcase
    irq_next = m_irq_en && (m_ovf || (m_thr != 0 && n >= int'(m_thr)));
    push_req = m_en && (prb != m_prev || !m_was_en);
    do_pop   = rd && a == 2'd3 && n > 0;
    clr      = wr && a == 2'd0 && d[1];
    if (clr) begin
      q_ts.delete(); q_val.delete(); m_ovf = 0; m_ts = 0;
    end else begin
      if (wr && a == 2'd1 && d[10]) m_ovf = 0;
      if (do_pop) begin void'(q_ts.pop_front()); void'(q_val.pop_front()); end
      if (push_req) begin
        if (q_val.size() < DEPTH) begin q_ts.push_back(m_ts); q_val.push_back(prb); end
        else m_ovf = 1;
      end
      m_ts = (m_ts + 1) & TS_MASK;
    end
    m_was_en = m_en;
    if (m_en) m_prev = prb;
    if (wr && a == 2'd0) begin m_en = d[0]; m_irq_en = d[2]; m_thr = d[14:8]; end
    exp_ack = acc;
    exp_dat = rd ? rdata : 0;
    exp_irq = irq_next;
  endtask

  // Called at a negedge; drives one cycle, checks after the edge, returns at the next negedge.
  task automatic step(input bit cyc, input bit stb, input bit sio, input bit we,
                      input bit [3:0] sel, input bit [29:0] adr, input bit [31:0] d,
                      input bit [31:0] prb);
    bit acc;
    wb_cyc = cyc; wb_stb = stb; wb_sel_io = sio; wb_we = we;
    wb_sel = sel; wb_adr = adr; wb_dat_i = d; probe = prb;
    acc = cyc && stb && sio;
    model_step(acc, we, sel, adr[1:0], d, prb);
    @(posedge ext_clk); #1;
    check_val("ack", {31'h0, wb_ack}, {31'h0, exp_ack});
    check_val("dat", wb_dat_o, exp_dat);
    check_val("irq", {31'h0, irq}, {31'h0, exp_irq});
    if (acc)
      $display("[%0t] %s adr=%0d wdata=0x%08h rdata=0x%08h", $time,
               we ? "WR" : "RD", adr[1:0], d, wb_dat_o);
    @(negedge ext_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 30'h0, 32'h0, cur_probe);
  endtask

  task automatic bus_wr(input bit [1:0] a, input bit [31:0] d);
    step(1, 1, 1, 1, 4'hF, {28'h0, a}, d, cur_probe);
  endtask

  task automatic bus_rd(input bit [1:0] a, output logic [31:0] d);
    step(1, 1, 1, 0, 4'hF, {28'h0, a}, 32'h0, cur_probe);
    d = wb_dat_o;
  endtask

  task automatic do_reset();
    ext_rst_n = 0;
    wb_cyc = 0; wb_stb = 0; wb_sel_io = 0; wb_we = 0;
    wb_sel = 0; wb_adr = 0; wb_dat_i = 0; probe = cur_probe;
    repeat (2) @(negedge ext_clk);
    ext_rst_n = 1;
    model_reset();
  endtask

  initial begin
    logic [31:0] rv, t1, t2, t3;
    bit cyc, stb, sio, we;
    bit [3:0] sel;
    bit [29:0] adr;
    bit [31:0] d;
    int phase;

    cur_probe = 0;
    do_reset();
    check_val("rst_ack", {31'h0, wb_ack}, 32'h0);
    check_val("rst_dat", wb_dat_o, 32'h0);
    check_val("rst_irq", {31'h0, irq}, 32'h0);
    check_val("rst_stall", {31'h0, wb_stall}, 32'h0);
    bus_rd(2'd1, rv);
    check_val("rst_status", rv, 32'h100);

    // Three distinct values captured in order
    bus_wr(2'd0, 32'h1);
    idle(1);
    cur_probe = 32'h5; idle(1);
    cur_probe = 32'hA; idle(1);
    idle(1);
    bus_rd(2'd1, rv); check_val("cnt3", rv, 32'h3);
    bus_rd(2'd2, t1); bus_rd(2'd3, rv); check_val("d0", rv, 32'h0);
    bus_rd(2'd2, t2); bus_rd(2'd3, rv); check_val("d5", rv, 32'h5);
    bus_rd(2'd2, t3); bus_rd(2'd3, rv); check_val("dA", rv, 32'hA);
    check_val("ts_order", {31'h0, t2 > t1}, 32'h1);
    check_val("ts_step", t3 - t2, 32'h1);
    bus_rd(2'd3, rv); check_val("d_empty", rv, 32'h0);
    bus_rd(2'd1, rv); check_val("empty_status", rv, 32'h100);

    // Constant probe: only the baseline entry
    bus_wr(2'd0, 32'h2);
    bus_wr(2'd0, 32'h1);
    idle(100);
    bus_rd(2'd1, rv); check_val("hold_cnt1", rv, 32'h1);
    bus_rd(2'd3, rv); check_val("hold_val", rv, 32'hA);
    bus_rd(2'd3, rv); check_val("hold_empty", rv, 32'h0);
    bus_rd(2'd1, rv); check_val("hold_status", rv, 32'h100);

    // Overflow with irq_en
    bus_wr(2'd0, 32'h2);
    bus_wr(2'd0, 32'h5);
    for (int i = 0; i < 20; i++) begin cur_probe = cur_probe ^ 32'h1; idle(1); end
    bus_rd(2'd1, rv); check_val("ovf_status", rv, 32'h610);
    check_val("ovf_irq", {31'h0, irq}, 32'h1);
    bus_wr(2'd1, 32'h400);
    bus_rd(2'd1, rv); check_val("w1c_status", rv, 32'h210);
    idle(1); check_val("w1c_irq", {31'h0, irq}, 32'h0);

    // Full: simultaneous pop and push keeps count, no overflow
    cur_probe = cur_probe ^ 32'h100;
    bus_rd(2'd3, rv);
    bus_rd(2'd1, rv); check_val("full_pushpop", rv, 32'h210);

    // Threshold interrupt then clear
    bus_wr(2'd0, 32'h2);
    bus_wr(2'd0, 32'h405);
    idle(1);
    cur_probe = cur_probe + 1; idle(1);
    cur_probe = cur_probe + 1; idle(1);
    cur_probe = cur_probe + 1; idle(1);
    check_val("thr_irq_lo", {31'h0, irq}, 32'h0);
    idle(1);
    check_val("thr_irq_hi", {31'h0, irq}, 32'h1);
    bus_wr(2'd0, 32'h407);
    idle(1);
    check_val("clr_irq", {31'h0, irq}, 32'h0);
    bus_rd(2'd2, rv); check_val("clr_head_ts", rv, 32'h0);
    bus_rd(2'd1, rv); check_val("clr_status", rv, 32'h100);

    // Reset while an ack is outstanding
    bus_wr(2'd0, 32'h1);
    cur_probe = cur_probe ^ 32'hFF; idle(2);
    step(1, 1, 1, 0, 4'hF, 30'h1, 32'h0, cur_probe);
    ext_rst_n = 0; #1;
    check_val("mid_rst_ack", {31'h0, wb_ack}, 32'h0);
    check_val("mid_rst_dat", wb_dat_o, 32'h0);
    @(negedge ext_clk);
    do_reset();
    bus_rd(2'd1, rv); check_val("mid_rst_status", rv, 32'h100);

    // Randomized traffic: alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 2500; i++) begin
      phase = (i / 200) % 2;
      cyc = ($urandom_range(0, 3) != 0);
      stb = $urandom_range(0, 1);
      sio = ($urandom_range(0, 7) != 0);
      adr = $urandom;
      if (phase == 1 && $urandom_range(0, 9) < 7) adr[1:0] = 2'd3;
      we  = (phase == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) == 0);
      sel = $urandom;
      sel[0] = ($urandom_range(0, 9) != 0);
      d = $urandom;
      d[0] = ($urandom_range(0, 7) != 0);
      d[1] = ($urandom_range(0, 9) == 0);
      d[14:8] = $urandom_range(0, 20);
      if (phase == 0 ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0))
        cur_probe = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 3);
      step(cyc, stb, sio, we, sel, adr, d, cur_probe);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ext_io_trace_buffer.md
# ext_io_trace_buffer

Wishbone slave on the SoC's external-IO port (`wb_ext_io_in`/`wb_ext_io_out`, 32-bit pipelined) that captures GPIO value changes into a timestamped FIFO for the hardware debugger. When enabled, it samples a 32-bit probe bus every cycle and pushes `{timestamp, value}` whenever the value changes. The CPU drains the FIFO through four memory-mapped registers. A level interrupt fires on a fill threshold or on overflow.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..64.
- `TS_W`, 16: timestamp counter width, at most 32.

- `ext_clk`  in  1  system clock; all logic on the rising edge.
- `ext_rst_n`  in  1  asynchronous, active-low reset.
- `wb_sel_io`  in  1  address-decode select; the block responds only when this is high.
- `wb_adr`  in  30  word address; only `wb_adr[1:0]` is decoded.
- `wb_dat_i`  in  32  write data.
- `wb_sel`  in  4  byte enables; only lane 0 (`wb_sel[0]`) gates writes.
- `wb_cyc`, `wb_stb`, `wb_we`  in  1 each  Wishbone control.
- `wb_dat_o`  out  32  read data, valid when `wb_ack` is high.
- `wb_ack`  out  1  transfer acknowledge.
- `wb_stall`  out  1  tied to 0.
- `probe`  in  32  bus to trace; synchronous to `ext_clk`.
- `irq`  out  1  level interrupt.

## Operation
Registers (word offset):
- 0 CTRL (R/W): `[0]` enable, `[1]` clear (write-1, self-clearing, reads 0), `[2]` irq_en, `[8+:7]` threshold.
- 1 STATUS (RO; W1C on bit 10): `[6:0]` count, `[8]` empty, `[9]` full, `[10]` overflow (sticky).
- 2 HEAD_TS (RO): timestamp of the head entry, zero-extended. Returns 0 when empty. Does not pop.
- 3 DATA (RO): head probe value. A read pops the head. A read when empty returns 0 and does not pop.

Capture:
- Timestamp counter increments every cycle, wraps modulo 2^TS_W, and zeroes on clear.
- While enable is 1, a `prev` register loads `probe` every cycle.
- A push is requested when `probe != prev`, or on the first cycle after enable rises (unconditional).
- While enable is 0, there are no pushes and `prev` holds.
- Pushed entry is `{timestamp, probe}` from the same cycle.

FIFO:
- Circular buffer of `DEPTH` entries with read/write pointers and a `$clog2(DEPTH)+1`-bit count.
- Push while full: entry dropped, overflow set to 1.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds when full (no overflow) and when count is 1.
- Push and pop in the same cycle while empty: the pop is a no-op (returns 0) and the push is accepted.
- Clear: pointers, count, overflow and timestamp go to 0 on the next edge. Clear takes priority over a same-cycle push or pop.
- Writes to offsets 1–3 have no effect, except the STATUS bit-10 W1C.

Interrupt:
- `irq` = irq_en & (overflow | (threshold != 0 & count >= threshold)).
- Registered, so it updates one cycle after its inputs change.

## Timing
- Reset: `wb_ack` 0, `wb_dat_o` 0, `wb_stall` 0, `irq` 0. CTRL 0, count 0, overflow 0, timestamp 0, `prev` 0, pointers 0.
- A transfer is accepted on any edge with `wb_cyc & wb_stb & wb_sel_io`.
- `wb_ack` is asserted exactly one cycle after acceptance, for one cycle, with `wb_dat_o` registered alongside it.
- Back-to-back accepts give back-to-back acks, one per request.
- `wb_dat_o` returns to 0 when `wb_ack` is low.
- Register write effects are visible from the acceptance edge.
- DATA pop happens on the acceptance edge. Two consecutive DATA reads return consecutive entries.
- Capture-to-visibility latency: a change on `probe` at edge N is pushed at edge N+1 and counted in STATUS from edge N+1.
- Reset mid-transfer: any pending ack is dropped and the FIFO is emptied.
- A request dropping `wb_cyc` before its ack still completes its side effect.

## Test plan
- Reset, then read STATUS → `wb_dat_o` = 0x100 (empty) with ack one cycle after the request; `irq` = 0.
- Enable with `probe` = 0x0; step `probe` to 0x5 and then 0xA on separate cycles → count = 3. DATA reads return 0x0, 0x5, 0xA; HEAD_TS values are strictly increasing with a difference of 1 between the last two.
- Hold `probe` constant for 100 cycles after the first push → count stays at 1. A fourth DATA read on an empty FIFO returns 0 and count stays at 0.
- Toggle `probe` for 20 cycles with DEPTH = 16 → count = 16, full = 1, overflow = 1, `irq` = 1 with irq_en set. Writing STATUS with 0x400 clears overflow.
- Fill to full, then DATA-read on the same cycle as a probe change → count stays 16 and overflow stays 0.
- Set threshold = 4 and irq_en = 1, push 4 entries → `irq` rises one cycle after count reaches 4. Writing CTRL clear → count 0, `irq` 0 two cycles later, HEAD_TS = 0.
